// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its hazard controller.
// Latch-control encoding on *_state: 2'd0 enable, 2'd1 stall, 2'd2 insert bubble (nop).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic             dREN_mem;
  logic             dWEN_mem;
  logic             redirect_mem;
  logic             halt_mem;
  logic             memread_ex;
  logic [4:0]       regWSEL_ex;
  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic [1:0]       fd_state;
  logic [1:0]       de_state;
  logic [1:0]       em_state;
  logic [1:0]       mw_state;
  logic             pc_en;
  logic             halted;
  logic             timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ihit, dhit, dREN_mem, dWEN_mem, redirect_mem, halt_mem,
           memread_ex, regWSEL_ex, rs_id, rt_id,
    input  fd_state, de_state, em_state, mw_state, pc_en, halted, timeout, stall_cnt
  );

  modport slave (
    input  ihit, dhit, dREN_mem, dWEN_mem, redirect_mem, halt_mem,
           memread_ex, regWSEL_ex, rs_id, rt_id,
    output fd_state, de_state, em_state, mw_state, pc_en, halted, timeout, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/halt controller for the 5-stage core: drives every stage latch
// and the PC enable, and keeps stall statistics plus a D-memory watchdog.
//  state | meaning
//  RUN   | normal issue; hazards resolved combinationally
//  DWAIT | data access outstanding, whole pipe frozen
//  FLUSH | fetch in flight is wrong-path, its word gets dropped
//  HALT  | halt retired, pipe frozen until reset
module pipeline_hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input logic              CLK,
  input logic              nRST,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam logic [1:0]  PIPE_ENABLE = 2'd0;
  localparam logic [1:0]  PIPE_STALL  = 2'd1;
  localparam logic [1:0]  PIPE_NOP    = 2'd2;
  localparam bit          WD_EN       = (TIMEOUT > 0);
  localparam logic [31:0] WD_LAST     = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  typedef enum logic [1:0] {RUN, DWAIT, FLUSH, HALT} state_t;

  state_t           r_state, w_next, w_rnext;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [31:0]      r_wd_cnt;
  logic             r_timeout;
  logic             w_dmiss, w_load_use;
  logic [1:0]       w_fd, w_de, w_em, w_mw;
  logic [1:0]       w_rfd, w_rde, w_rem;
  logic             w_pc_en, w_rpc, w_wd_inc, w_wd_clr;

  assign w_dmiss    = (bus.dREN_mem | bus.dWEN_mem) & ~bus.dhit;
  assign w_load_use = bus.memread_ex & (bus.regWSEL_ex != 5'd0) &
                      ((bus.regWSEL_ex == bus.rs_id) | (bus.regWSEL_ex == bus.rt_id));

  // Redirect / load-use / fetch-miss resolution, shared by RUN and a completing DWAIT.
  always_comb begin
    w_rfd   = PIPE_ENABLE;
    w_rde   = PIPE_ENABLE;
    w_rem   = PIPE_ENABLE;
    w_rpc   = 1'b1;
    w_rnext = RUN;
    if (bus.redirect_mem) begin
      w_rfd   = PIPE_NOP;
      w_rde   = PIPE_NOP;
      w_rem   = PIPE_NOP;
      w_rnext = bus.ihit ? RUN : FLUSH;
    end else if (w_load_use) begin
      w_rfd = PIPE_STALL;
      w_rde = PIPE_NOP;
      w_rpc = 1'b0;
    end else if (!bus.ihit) begin
      w_rfd = PIPE_NOP;
      w_rpc = 1'b0;
    end
  end

  always_comb begin
    w_fd     = PIPE_ENABLE;
    w_de     = PIPE_ENABLE;
    w_em     = PIPE_ENABLE;
    w_mw     = PIPE_ENABLE;
    w_pc_en  = 1'b0;
    w_next   = r_state;
    w_wd_inc = 1'b0;
    w_wd_clr = 1'b0;
    case (r_state)
      RUN, FLUSH: begin
        if (bus.halt_mem) begin
          w_fd   = PIPE_NOP;
          w_de   = PIPE_NOP;
          w_em   = PIPE_NOP;
          w_next = HALT;
        end else if (w_dmiss) begin
          w_fd   = PIPE_STALL;
          w_de   = PIPE_STALL;
          w_em   = PIPE_STALL;
          w_mw   = PIPE_STALL;
          w_next = DWAIT;
        end else if (r_state == RUN) begin
          w_fd    = w_rfd;
          w_de    = w_rde;
          w_em    = w_rem;
          w_pc_en = w_rpc;
          w_next  = w_rnext;
        end else if (bus.redirect_mem) begin
          w_fd    = PIPE_NOP;
          w_de    = PIPE_NOP;
          w_em    = PIPE_NOP;
          w_pc_en = 1'b1;
        end else begin
          w_fd = PIPE_NOP;
          if (bus.ihit) w_next = RUN;
        end
      end
      DWAIT: begin
        if (!bus.dhit) begin
          w_fd     = PIPE_STALL;
          w_de     = PIPE_STALL;
          w_em     = PIPE_STALL;
          w_mw     = PIPE_STALL;
          w_wd_inc = 1'b1;
        end else begin
          w_fd     = w_rfd;
          w_de     = w_rde;
          w_em     = w_rem;
          w_pc_en  = w_rpc;
          w_next   = w_rnext;
          w_wd_clr = 1'b1;
        end
      end
      HALT: begin
        w_fd = PIPE_STALL;
        w_de = PIPE_STALL;
        w_em = PIPE_STALL;
        w_mw = PIPE_STALL;
      end
      default: w_next = RUN;
    endcase
    // Latches see bubbles for as long as reset is held, independent of the clock.
    if (!nRST) begin
      w_fd    = PIPE_NOP;
      w_de    = PIPE_NOP;
      w_em    = PIPE_NOP;
      w_mw    = PIPE_NOP;
      w_pc_en = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
      r_wd_cnt    <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (!w_pc_en && (r_state != HALT) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_wd_clr)
        r_wd_cnt <= '0;
      else if (w_wd_inc && (r_wd_cnt != '1))
        r_wd_cnt <= r_wd_cnt + 1'b1;
      if (WD_EN && w_wd_inc && (r_wd_cnt == WD_LAST))
        r_timeout <= 1'b1;
    end
  end

  assign bus.fd_state  = w_fd;
  assign bus.de_state  = w_de;
  assign bus.em_state  = w_em;
  assign bus.mw_state  = w_mw;
  assign bus.pc_en     = w_pc_en;
  assign bus.halted    = (r_state == HALT);
  assign bus.timeout   = r_timeout;
  assign bus.stall_cnt = r_stall_cnt;
endmodule
